// File: rtl/msg_pkg.sv
// Shared types and constants for the six-slot hex message entry front end.
package msg_pkg;
  typedef enum logic {
    ENTRY  = 1'b0,
    SCROLL = 1'b1
  } mode_e;

  localparam int         SLOTS     = 6;
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } slot_t;
endpackage

// File: rtl/hex7seg.sv
// Maps one buffer slot to active-low seven-segment drive (g..a); invalid slots blank.
module hex7seg
  import msg_pkg::*;
(
  input  slot_t      slot,
  output logic [6:0] seg
);
  always_comb begin
    seg = BLANK_SEG;
    if (slot.valid) begin
      unique case (slot.code)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        4'hF: seg = 7'h0E;
        default: seg = BLANK_SEG;
      endcase
    end
  end
endmodule

// File: rtl/hex_msg_entry.sv
// Message entry front end: captures hex characters from the switches into a six-slot
// buffer, supports backspace, and rotates the buffer across HEX5..HEX0 in scroll mode.
module hex_msg_entry
  import msg_pkg::*;
#(
  parameter int TICK_COUNT = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);
  localparam int TW = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;

  logic rst_n;
  assign rst_n = KEY[0];

  logic unused_sw;
  assign unused_sw = ^SW[9:4];

  // Button bit 0 = enter (KEY1), bit 1 = mode (KEY2), bit 2 = backspace (KEY3).
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, press;

  slot_t          slots_q [SLOTS];
  slot_t          slots_d [SLOTS];
  logic  [2:0]    count_q, count_d;
  mode_e          mode_q, mode_d;
  logic  [2:0]    offset_q, offset_d;
  logic  [TW-1:0] tick_q, tick_d;
  logic           wrap;

  always_comb begin
    sync1_d  = KEY[3:1];
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    press    = prev_q & ~sync2_q;

    slots_d  = slots_q;
    count_d  = count_q;
    mode_d   = mode_q;
    offset_d = offset_q;
    wrap     = (tick_q == TW'(TICK_COUNT - 1));
    tick_d   = wrap ? '0 : tick_q + 1'b1;

    if (press[1]) begin
      if (mode_q == SCROLL) begin
        mode_d   = ENTRY;
        offset_d = '0;
        tick_d   = '0;
      end else if (count_q != 3'd0) begin
        mode_d   = SCROLL;
        offset_d = '0;
        tick_d   = '0;
      end
    end else if (press[2]) begin
      if (mode_q == ENTRY && count_q != 3'd0) begin
        for (int k = 1; k < SLOTS; k++) slots_d[k-1] = slots_q[k];
        slots_d[SLOTS-1] = '0;
        count_d          = count_q - 3'd1;
      end
    end else if (press[0]) begin
      if (mode_q == ENTRY && count_q != 3'(SLOTS)) begin
        for (int k = SLOTS - 1; k > 0; k--) slots_d[k] = slots_q[k-1];
        slots_d[0] = slot_t'{valid: 1'b1, code: SW[3:0]};
        count_d    = count_q + 3'd1;
      end
    end

    // A mode press on a wrap cycle has already cleared the offset above.
    if (!press[1] && mode_q == SCROLL && wrap)
      offset_d = (offset_q == 3'd5) ? 3'd0 : offset_q + 3'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 3'b111;
      sync2_q  <= 3'b111;
      prev_q   <= 3'b111;
      for (int k = 0; k < SLOTS; k++) slots_q[k] <= '0;
      count_q  <= '0;
      mode_q   <= ENTRY;
      offset_q <= '0;
      tick_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      slots_q  <= slots_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      offset_q <= offset_d;
      tick_q   <= tick_d;
    end
  end

  // HEXk shows slot[(k - offset) mod 6].
  slot_t      seg_in [SLOTS];
  logic [6:0] seg    [SLOTS];
  logic [2:0] idx;

  always_comb begin
    idx = '0;
    for (int k = 0; k < SLOTS; k++) begin
      idx = (3'(k) >= offset_q) ? 3'(k) - offset_q : 3'(k) + 3'd6 - offset_q;
      seg_in[k] = slots_q[idx];
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_dig
    hex7seg u_seg (
      .slot(seg_in[g]),
      .seg (seg[g])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];

  assign LEDR = {mode_q == SCROLL, count_q == 3'(SLOTS), 5'b0, count_q};
endmodule

// File: tb/tb_hex_msg_entry.sv
// Directed bench for hex_msg_entry with a four-cycle scroll step.
module tb_hex_msg_entry;
  logic       clk = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW  = '0;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int passed = 0;
  int total  = 0;

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] DE1_OFF0  = {7'h7F, 7'h7F, 7'h7F, 7'h21, 7'h06, 7'h79};
  localparam logic [41:0] DE1_OFF1  = {7'h7F, 7'h7F, 7'h21, 7'h06, 7'h79, 7'h7F};

  hex_msg_entry #(.TICK_COUNT(4)) dut (
    .CLOCK_50(clk), .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] hexes();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic do_reset();
    @(negedge clk) KEY = 4'b1110;
    repeat (2) @(negedge clk);
    KEY = 4'hF;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int b, input logic [3:0] ch);
    @(negedge clk) SW = {6'b0, ch}; KEY[b] = 1'b0;
    repeat (4) @(negedge clk);
    KEY[b] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk) KEY = 4'b1110;
    repeat (3) @(negedge clk);
    total++; if (hexes() !== ALL_BLANK) $display("FAIL rst_hex got %h exp %h", hexes(), ALL_BLANK); else passed++;
    total++; if (LEDR !== 10'h000) $display("FAIL rst_ledr got %h exp 000", LEDR); else passed++;
    KEY = 4'hF;
    repeat (6) @(negedge clk);
    total++; if (LEDR !== 10'h000) $display("FAIL rel_ledr got %h exp 000", LEDR); else passed++;
    total++; if (hexes() !== ALL_BLANK) $display("FAIL rel_hex got %h exp %h", hexes(), ALL_BLANK); else passed++;
  endtask

  task automatic test_enter();
    do_reset();
    press(1, 4'hD);
    total++; if (LEDR !== 10'h001) $display("FAIL enter1_ledr got %h exp 001", LEDR); else passed++;
    press(1, 4'hE);
    total++; if (LEDR !== 10'h002) $display("FAIL enter2_ledr got %h exp 002", LEDR); else passed++;
    press(1, 4'h1);
    total++; if (LEDR !== 10'h003) $display("FAIL enter3_ledr got %h exp 003", LEDR); else passed++;
    total++; if (hexes() !== DE1_OFF0) $display("FAIL enter_hex got %h exp %h", hexes(), DE1_OFF0); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 6; i++) press(1, 4'(i));
    total++; if (LEDR !== 10'h106) $display("FAIL full_ledr got %h exp 106", LEDR); else passed++;
    press(1, 4'h6);
    total++; if (LEDR !== 10'h106) $display("FAIL full7_ledr got %h exp 106", LEDR); else passed++;
    total++; if (hexes() !== {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12})
      $display("FAIL full_hex got %h exp %h", hexes(), {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}); else passed++;
  endtask

  task automatic test_backspace();
    test_enter();
    press(3, 4'h0);
    total++; if (LEDR !== 10'h002) $display("FAIL bs1_ledr got %h exp 002", LEDR); else passed++;
    press(3, 4'h0);
    total++; if (LEDR !== 10'h001) $display("FAIL bs2_ledr got %h exp 001", LEDR); else passed++;
    total++; if (hexes() !== {{5{7'h7F}}, 7'h21}) $display("FAIL bs2_hex got %h exp %h", hexes(), {{5{7'h7F}}, 7'h21}); else passed++;
    press(3, 4'h0);
    press(3, 4'h0);
    total++; if (LEDR !== 10'h000) $display("FAIL bs_empty_ledr got %h exp 000", LEDR); else passed++;
    total++; if (hexes() !== ALL_BLANK) $display("FAIL bs_empty_hex got %h exp %h", hexes(), ALL_BLANK); else passed++;
  endtask

  task automatic test_scroll();
    test_enter();
    @(negedge clk) KEY[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (LEDR !== 10'h203) $display("FAIL scr_ledr got %h exp 203", LEDR); else passed++;
    total++; if (hexes() !== DE1_OFF0) $display("FAIL scr_off0 got %h exp %h", hexes(), DE1_OFF0); else passed++;
    KEY[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (hexes() !== DE1_OFF0) $display("FAIL scr_pre_step got %h exp %h", hexes(), DE1_OFF0); else passed++;
    @(posedge clk) #1;
    total++; if (hexes() !== DE1_OFF1) $display("FAIL scr_step1 got %h exp %h", hexes(), DE1_OFF1); else passed++;
    repeat (20) @(posedge clk);
    #1;
    total++; if (hexes() !== DE1_OFF0) $display("FAIL scr_wrap24 got %h exp %h", hexes(), DE1_OFF0); else passed++;
    repeat (4) @(posedge clk);
    #1;
    total++; if (hexes() !== DE1_OFF1) $display("FAIL scr_step7 got %h exp %h", hexes(), DE1_OFF1); else passed++;
    press(2, 4'h0);
    total++; if (LEDR !== 10'h003) $display("FAIL scr_exit_ledr got %h exp 003", LEDR); else passed++;
    total++; if (hexes() !== DE1_OFF0) $display("FAIL scr_exit_hex got %h exp %h", hexes(), DE1_OFF0); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    press(1, 4'h1);
    press(1, 4'h2);
    @(negedge clk) KEY[1] = 1'b0; KEY[3] = 1'b0;
    repeat (4) @(negedge clk);
    KEY[1] = 1'b1; KEY[3] = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (LEDR !== 10'h001) $display("FAIL prio_ledr got %h exp 001", LEDR); else passed++;
    total++; if (hexes() !== {{5{7'h7F}}, 7'h79}) $display("FAIL prio_hex got %h exp %h", hexes(), {{5{7'h7F}}, 7'h79}); else passed++;
  endtask

  task automatic test_mode_empty();
    do_reset();
    press(2, 4'h0);
    total++; if (LEDR !== 10'h000) $display("FAIL mode_empty_ledr got %h exp 000", LEDR); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    press(1, 4'hA);
    press(2, 4'h0);
    total++; if (LEDR !== 10'h201) $display("FAIL ar_pre_ledr got %h exp 201", LEDR); else passed++;
    @(posedge clk) #3 KEY[0] = 1'b0;
    #1;
    total++; if (hexes() !== ALL_BLANK) $display("FAIL ar_hex got %h exp %h", hexes(), ALL_BLANK); else passed++;
    total++; if (LEDR !== 10'h000) $display("FAIL ar_ledr got %h exp 000", LEDR); else passed++;
    @(negedge clk) KEY = 4'hF;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_enter();
    test_full();
    test_backspace();
    test_scroll();
    test_priority();
    test_mode_empty();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hex_msg_entry.md
# hex_msg_entry

Message-entry front end for the DE1 six-digit display. The user keys up to six hex characters from the switches into a six-slot buffer, edits them with backspace, then switches to scroll mode, where the buffer rotates across HEX5..HEX0 at a fixed rate. This block writes the display buffer that the rotating-message display reads: it owns character capture, editing and rotation, and decodes every slot to active-low segments.

## Interface
- TICK_COUNT, 50_000_000: CLOCK_50 cycles per scroll step (1 Hz at 50 MHz); must be ≥ 2.
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- KEY  in  4  active-low pushbuttons.
  - KEY[0]: reset, asynchronous and active-low.
  - KEY[1]: enter.
  - KEY[2]: mode toggle.
  - KEY[3]: backspace.
- SW  in  10  SW[3:0] is the character code 0x0–0xF; SW[9:4] is unused.
- LEDR  out  10  status.
  - [2:0]: character count 0–6.
  - [8]: full (count == 6).
  - [9]: scroll mode.
  - all other bits 0.
- HEX5..HEX0  out  7 each  active-low segments [6:0] = g..a; a blank digit is 7'h7F.

## Operation
- Buffer: slots 5..0, each a valid bit plus a 4-bit code; `count` is 0–6. Valid slots are always contiguous from slot 0 upward.
- Button conditioning for KEY[3:1]:
  - Each button passes through a two-flop synchronizer and then a previous-value register.
  - press = prev & ~sync: a single-cycle pulse per falling edge.
  - Holding a button produces exactly one press.
- State machine {ENTRY, SCROLL}; reset state is ENTRY.
- ENTRY, enter press:
  - If count < 6: slot[k] <= slot[k-1] for k = 5..1, slot0 <= {1, SW[3:0]}, count++.
  - If count == 6: ignored, buffer unchanged.
- ENTRY, backspace press:
  - If count > 0: slot[k-1] <= slot[k] for k = 1..5, slot5 <= invalid, count--.
  - If count == 0: ignored.
- ENTRY, mode press:
  - If count > 0: go to SCROLL; tick counter and offset cleared.
  - If count == 0: stay in ENTRY.
- SCROLL:
  - Enter and backspace presses are ignored.
  - Mode press returns to ENTRY; offset and tick counter are cleared, the buffer is untouched.
- Simultaneous presses in one cycle: priority mode > backspace > enter. Only the winning action executes; the others are dropped.
- Rotation:
  - The tick counter counts 0..TICK_COUNT-1 and wraps.
  - On the wrap cycle in SCROLL: offset <= (offset == 5) ? 0 : offset + 1.
- Display mapping: HEXk shows slot[(k − offset) mod 6]. An invalid slot shows blank; a valid slot shows the hex glyph 0–9, A, b, C, d, E, F.
- Reset (KEY[0] low, asynchronous, effective immediately, including mid-scroll or mid-press):
  - all slots invalid, count 0, mode ENTRY, offset 0, tick 0;
  - synchronizer and previous-value registers set to 1 (unpressed), so releasing reset never creates a false press;
  - HEX5..HEX0 = 7'h7F, LEDR = 0.

## Timing
- Button latency: a KEY level sampled low at edge N produces a press during the cycle after edge N+1. The resulting buffer, count or mode update is visible on outputs after edge N+2, so three edges from first low sample to visible update.
- HEX and LEDR are combinational from registered state; no extra pipeline stage.
- Scroll step period: exactly TICK_COUNT cycles.
  - The first step occurs TICK_COUNT cycles after the edge that entered SCROLL.
  - The tick counter runs in ENTRY but has no effect there.
- A mode press on the same cycle as a tick wrap: the mode change wins and offset is cleared, not incremented.

## Structure
- Package msg_pkg holds:
  - mode encoding (ENTRY = 1'b0, SCROLL = 1'b1);
  - SLOTS = 6;
  - BLANK_SEG = 7'h7F;
  - the slot record layout (valid + code, 5 bits).
- One sub-module, hex7seg: combinational, maps {valid, code} to 7-bit active-low segments, instantiated six times.
- The synchronizer/edge detector is inline; no separate module.

## Test plan
All scenarios use TICK_COUNT = 4.
- Reset with all buttons released, then release KEY[0] → HEX all 7'h7F, LEDR = 0, no press registered.
- Enter 0xD, 0xE, 0x1 via KEY[1] → after the third press's visible-update edge, HEX2..HEX0 = d, E, 1 (7'h21, 7'h06, 7'h79); HEX5..HEX3 blank; LEDR[2:0] = 3.
- Seven enter presses of 0x0..0x6 → buffer holds 0–5 in HEX5..HEX0; seventh press ignored; LEDR[8] = 1, count = 6.
- Backspace ×2 from count 3, then backspace on an empty buffer → count goes 1 then stays 0; HEX0 blank.
- Enter "d,E,1", then mode press → after 4 cycles d,E,1 shift to HEX3..HEX1; after 24 cycles the original position returns; mode press restores offset 0.
- Combined conditions:
  - KEY[1] and KEY[3] pressed in the same cycle at count 2 → only backspace executes, count becomes 1.
  - Mode press at count 0 → stays in ENTRY.
  - KEY[0] asserted mid-scroll → outputs blank immediately, asynchronously.
